// File: rtl/mux4_rr_arbiter_if.sv
// mux4_rr_arbiter_if: request/data/grant bundle between four requesters and the arbiter
interface mux4_rr_arbiter_if #(parameter int WIDTH = 31);
  logic [3:0] req;
  logic [WIDTH:0] in1, in2, in3, in4;
  logic out_ready;
  logic [3:0] grant;
  logic [1:0] sel;
  logic out_valid;
  logic [WIDTH:0] data_out;
  logic [3:0] beat_ack;
  modport master (output req, in1, in2, in3, in4, out_ready, input grant, sel, out_valid, data_out, beat_ack);
  modport slave (input req, in1, in2, in3, in4, out_ready, output grant, sel, out_valid, data_out, beat_ack);
endinterface

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin owner of a shared 4:1 datapath mux with per-grant beat cap
module mux4x1 #(parameter int WIDTH = 31) (
  input  logic [WIDTH:0] in1,
  input  logic [WIDTH:0] in2,
  input  logic [WIDTH:0] in3,
  input  logic [WIDTH:0] in4,
  input  logic [1:0]     sel,
  output logic [WIDTH:0] out
);
  assign out = sel[1] ? (sel[0] ? in4 : in3) : (sel[0] ? in2 : in1);
endmodule

module mux4_rr_arbiter #(
  parameter int WIDTH = 31,
  parameter int MAX_BEATS = 4
) (
  input logic clk,
  input logic rst_n,
  mux4_rr_arbiter_if.slave bus
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nxt;
  logic [3:0] grant_nxt, beat_cnt, cnt_nxt, rot;
  logic [1:0] sel_nxt, last, last_nxt, pos, w;
  logic [7:0] dbl;
  logic accept, rel;
  assign dbl = {bus.req, bus.req};
  assign rot = dbl[{1'b0, last} + 3'd1 +: 4];
  assign pos = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
  assign w = last + 2'd1 + pos;
  assign bus.out_valid = (state == BUSY) && bus.req[bus.sel];
  assign accept = bus.out_valid && bus.out_ready;
  assign bus.beat_ack = accept ? 4'b0001 << bus.sel : 4'b0000;
  assign rel = (state == BUSY) && (!bus.req[bus.sel] || (accept && beat_cnt == 4'(MAX_BEATS - 1)));
  mux4x1 #(.WIDTH(WIDTH)) u_mux (
    .in1(bus.in1), .in2(bus.in2), .in3(bus.in3), .in4(bus.in4),
    .sel(bus.sel), .out(bus.data_out)
  );
  always_comb begin
    state_nxt = state;
    grant_nxt = bus.grant;
    sel_nxt = bus.sel;
    last_nxt = last;
    cnt_nxt = accept ? beat_cnt + 4'd1 : beat_cnt;
    if ((state == IDLE || rel) && |bus.req) begin
      state_nxt = BUSY;
      grant_nxt = 4'b0001 << w;
      sel_nxt = w;
      last_nxt = w;
      cnt_nxt = 4'd0;
    end else if (rel) begin
      state_nxt = IDLE;
      grant_nxt = 4'b0000;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      bus.grant <= 4'b0000;
      bus.sel <= 2'd0;
      beat_cnt <= 4'd0;
      last <= 2'd3;
    end else begin
      state <= state_nxt;
      bus.grant <= grant_nxt;
      bus.sel <= sel_nxt;
      beat_cnt <= cnt_nxt;
      last <= last_nxt;
    end
  end
endmodule
